reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  decode presents an instruction
- issue_rs  in  5  first source register
- issue_rt  in  5  second source register
- issue_rd  in  5  destination register
- issue_wr  in  1  instruction writes issue_rd
- issue_ready  out  1  instruction may issue this cycle
- wb_valid  in  1  pipeline WB-stage write request
- wb_rd  in  5  WB destination
- wb_data  in  32  WB data
- lu_valid  in  1  long-latency unit (mult/div) write request
- lu_rd  in  5  long-unit destination
- lu_data  in  32  long-unit data
- lu_ready  out  1  long-unit request accepted this cycle
- regWrite  out  1  register-file write enable
- writeRegister  out  5  register-file write index
- writeData  out  32  register-file write data
- busy  out  32  pending-write bit per register
- stall_count  out  16  saturating count of stalled issue cycles
REQ-002 SHALL use one clock (clk) and a synchronous, active-high reset (reset).

Function
REQ-003 SHALL assert issue_ready combinationally = !reset & !starve & !busy[issue_rs] & !busy[issue_rt] & !(issue_wr & busy[issue_rd]), using registered busy only.
REQ-004 SHALL treat register 0 as never busy: busy[0] constant 0.
REQ-005 SHALL set busy[issue_rd] at the clock edge where issue_valid & issue_ready & issue_wr & issue_rd != 0.
REQ-006 SHALL grant the write port to WB with fixed priority: wb accepted whenever wb_valid; lu_ready = lu_valid & !wb_valid & !reset.
REQ-007 SHALL clear busy[rd] of the accepted write (wb_rd or lu_rd) at the edge of acceptance.
REQ-008 SHALL give set priority over clear if both target the same register in one cycle.
REQ-009 SHALL register the accepted write: regWrite, writeRegister, writeData valid exactly one cycle after acceptance, then regWrite returns to 0 unless another write was accepted.
REQ-010 SHALL suppress writes to register 0: regWrite = 0, busy unchanged, request still counted as accepted (lu_ready asserted).
REQ-011 SHALL keep a 3-bit lu_wait counter: increment while lu_valid & !lu_ready, clear when lu_ready or !lu_valid, saturate at 7.
REQ-012 SHALL assert internal starve when lu_wait >= 4, forcing issue_ready = 0 so the WB stream drains and lu is granted.
REQ-013 SHALL deassert starve the cycle after lu_ready is asserted.
REQ-014 SHALL increment stall_count on each cycle with issue_valid & !issue_ready & !reset, saturating at 16'hFFFF.
REQ-015 SHALL ignore issue_rs/rt/rd/wr when issue_valid = 0: no busy change, no stall count.
REQ-016 SHALL produce output latency of one cycle from write request acceptance to regWrite; busy clear visible on issue_ready the cycle after acceptance.

Reset
REQ-017 SHALL, on any clock edge with reset = 1, clear busy, lu_wait, starve, stall_count, regWrite, writeRegister and writeData to 0.
REQ-018 SHALL hold issue_ready = 0 and lu_ready = 0 while reset = 1; pending requests mid-operation are dropped and are not written after reset.
REQ-019 SHALL resume normal operation on the first edge after reset deasserts, with all registers non-busy.

Verification
REQ-020 Issue rd=8 with issue_wr -> busy[8]=1 next cycle; following issue with rs=8 -> issue_ready=0, stall_count increments by 1 per stalled cycle.
REQ-021 wb_valid with wb_rd=8, wb_data=32'h0000_00AA -> next cycle regWrite=1, writeRegister=8, writeData=32'hAA, busy[8]=0; stalled issue accepted that same cycle.
REQ-022 wb_valid and lu_valid same cycle (wb_rd=9, lu_rd=10) -> lu_ready=0; WB written first; lu written on the first cycle wb_valid=0.
REQ-023 lu_valid held while wb_valid=1 for 6 cycles -> starve from cycle 4, issue_ready=0; lu_ready once wb_valid drops; starve clears one cycle later.
REQ-024 Issue rd=0 and wb write to rd=0 -> busy stays 0, regWrite stays 0, issue_ready unaffected.
REQ-025 Assert reset with busy=32'h0000_0300 and lu pending -> after one edge: busy=0, stall_count=0, regWrite=0, no later write of the dropped lu data.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per register and merges the pipeline WB
// and long-latency unit write requests onto the single register-file write port.
module reg_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic [4:0]  issue_rd,
  input  logic        issue_wr,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData,
  output logic [31:0] busy,
  output logic [15:0] stall_count
);

  logic [31:0] busy_q, busy_d;
  logic [2:0]  lu_wait_q, lu_wait_d;
  logic [15:0] stall_q, stall_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] write_data_q, write_data_d;

  logic        starve;
  logic        acc_valid;
  logic [4:0]  acc_rd;
  logic [31:0] acc_data;
  logic        issue_fire;

  // Starvation is derived from the registered wait count, so it drops on the
  // cycle after the long unit is finally granted.
  assign starve = (lu_wait_q >= 3'd4);

  always_comb begin
    issue_ready = !reset && !starve
                  && !busy_q[issue_rs] && !busy_q[issue_rt]
                  && !(issue_wr && busy_q[issue_rd]);
    lu_ready    = lu_valid && !wb_valid && !reset;

    acc_valid   = (wb_valid && !reset) || lu_ready;
    acc_rd      = wb_valid ? wb_rd : lu_rd;
    acc_data    = wb_valid ? wb_data : lu_data;

    issue_fire  = issue_valid && issue_ready && issue_wr && (issue_rd != 5'd0);
  end

  always_comb begin
    busy_d = busy_q;
    // Clear first so a same-cycle set of the same register wins.
    if (acc_valid) begin
      busy_d[acc_rd] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    lu_wait_d = 3'd0;
    if (lu_valid && !lu_ready) begin
      lu_wait_d = (lu_wait_q == 3'd7) ? 3'd7 : lu_wait_q + 3'd1;
    end

    stall_d = stall_q;
    if (issue_valid && !issue_ready && !reset && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_comb begin
    reg_write_d  = acc_valid && (acc_rd != 5'd0);
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (reg_write_d) begin
      write_reg_d  = acc_rd;
      write_data_d = acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= 32'd0;
      lu_wait_q    <= 3'd0;
      stall_q      <= 16'd0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      busy_q       <= busy_d;
      lu_wait_q    <= lu_wait_d;
      stall_q      <= stall_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign busy          = busy_q;
  assign stall_count   = stall_q;
  assign regWrite      = reg_write_q;
  assign writeRegister = write_reg_q;
  assign writeData     = write_data_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: issue stalls, write-port arbitration,
// long-unit starvation, register-0 handling and mid-operation reset.
module tb_reg_scoreboard;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt, issue_rd;
  logic        issue_wr;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [31:0] busy;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  reg_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .busy(busy), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0; issue_wr = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic wr);
    issue_valid = 1; issue_rs = rs; issue_rt = rt; issue_rd = rd; issue_wr = wr;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    issue(5'd1, 5'd2, 5'd3, 1'b1);
    wb_valid = 1; wb_rd = 5'd5; wb_data = 32'h1234;
    lu_valid = 1; lu_rd = 5'd6;
    #1;
    n_checks++;
    if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL rst_issue_ready got %b exp 0", issue_ready); end
    n_checks++;
    if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_lu_ready got %b exp 0", lu_ready); end
    tick();
    n_checks++;
    if (busy !== 32'h0) begin n_fail++; $display("FAIL rst_busy got %h exp 0", busy); end
    n_checks++;
    if (stall_count !== 16'h0) begin n_fail++; $display("FAIL rst_stall got %0d exp 0", stall_count); end
    n_checks++;
    if (regWrite !== 1'b0) begin n_fail++; $display("FAIL rst_regWrite got %b exp 0", regWrite); end
    idle();
    reset = 0;
    tick();
    n_checks++;
    if (regWrite !== 1'b0) begin n_fail++; $display("FAIL rst_no_write_after got %b exp 0", regWrite); end
  endtask

  task automatic test_issue_stall();
    issue(5'd1, 5'd2, 5'd8, 1'b1);
    #1;
    n_checks++;
    if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL stall_first_ready got %b exp 1", issue_ready); end
    tick();
    n_checks++;
    if (busy !== 32'h0000_0100) begin n_fail++; $display("FAIL stall_busy8 got %h exp 00000100", busy); end
    issue(5'd8, 5'd0, 5'd3, 1'b1);
    #1;
    n_checks++;
    if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL stall_dep_ready got %b exp 0", issue_ready); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (stall_count !== 16'(k)) begin n_fail++; $display("FAIL stall_count_%0d got %0d exp %0d", k, stall_count, k); end
    end
  endtask

  task automatic test_wb_release();
    wb_valid = 1; wb_rd = 5'd8; wb_data = 32'h0000_00AA;
    #1;
    n_checks++;
    if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL wbrel_ready_before got %b exp 0", issue_ready); end
    tick();
    wb_valid = 0;
    #1;
    n_checks++;
    if (regWrite !== 1'b1 || writeRegister !== 5'd8 || writeData !== 32'hAA) begin
      n_fail++;
      $display("FAIL wbrel_write got we=%b reg=%0d data=%h exp we=1 reg=8 data=000000aa", regWrite, writeRegister, writeData);
    end
    n_checks++;
    if (busy !== 32'h0) begin n_fail++; $display("FAIL wbrel_busy got %h exp 0", busy); end
    n_checks++;
    if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL wbrel_ready_after got %b exp 1", issue_ready); end
    n_checks++;
    if (stall_count !== 16'd4) begin n_fail++; $display("FAIL wbrel_stall got %0d exp 4", stall_count); end
    tick();
    idle();
    n_checks++;
    if (busy !== 32'h0000_0008 || stall_count !== 16'd4 || regWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL wbrel_accepted got busy=%h stall=%0d we=%b exp busy=00000008 stall=4 we=0", busy, stall_count, regWrite);
    end
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h3;
    tick();
    idle();
    tick();
    n_checks++;
    if (busy !== 32'h0) begin n_fail++; $display("FAIL wbrel_clear3 got %h exp 0", busy); end
  endtask

  task automatic test_wb_lu_priority();
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    issue(5'd0, 5'd0, 5'd10, 1'b1);
    tick();
    idle();
    n_checks++;
    if (busy !== 32'h0000_0600) begin n_fail++; $display("FAIL prio_busy_setup got %h exp 00000600", busy); end
    wb_valid = 1; wb_rd = 5'd9;  wb_data = 32'h0000_0099;
    lu_valid = 1; lu_rd = 5'd10; lu_data = 32'h0000_1010;
    #1;
    n_checks++;
    if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL prio_lu_blocked got %b exp 0", lu_ready); end
    tick();
    wb_valid = 0;
    #1;
    n_checks++;
    if (regWrite !== 1'b1 || writeRegister !== 5'd9 || writeData !== 32'h99 || busy !== 32'h0000_0400) begin
      n_fail++;
      $display("FAIL prio_wb_first got we=%b reg=%0d data=%h busy=%h exp 1/9/00000099/00000400", regWrite, writeRegister, writeData, busy);
    end
    n_checks++;
    if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL prio_lu_grant got %b exp 1", lu_ready); end
    tick();
    lu_valid = 0;
    n_checks++;
    if (regWrite !== 1'b1 || writeRegister !== 5'd10 || writeData !== 32'h1010 || busy !== 32'h0) begin
      n_fail++;
      $display("FAIL prio_lu_write got we=%b reg=%0d data=%h busy=%h exp 1/10/00001010/0", regWrite, writeRegister, writeData, busy);
    end
    tick();
    n_checks++;
    if (regWrite !== 1'b0) begin n_fail++; $display("FAIL prio_we_drop got %b exp 0", regWrite); end
  endtask

  task automatic test_starve();
    idle();
    wb_valid = 1; wb_rd = 5'd12; wb_data = 32'hC;
    lu_valid = 1; lu_rd = 5'd13; lu_data = 32'h0000_D00D;
    for (int k = 1; k <= 9; k++) begin
      tick();
      n_checks++;
      if (issue_ready !== (k < 4) || lu_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL starve_cycle_%0d got ready=%b lu_ready=%b exp ready=%b lu_ready=0", k, issue_ready, lu_ready, (k < 4));
      end
    end
    wb_valid = 0;
    #1;
    n_checks++;
    if (lu_ready !== 1'b1 || issue_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_grant got lu_ready=%b ready=%b exp 1/0", lu_ready, issue_ready);
    end
    tick();
    lu_valid = 0;
    #1;
    n_checks++;
    if (issue_ready !== 1'b1 || regWrite !== 1'b1 || writeRegister !== 5'd13 || writeData !== 32'hD00D) begin
      n_fail++;
      $display("FAIL starve_release got ready=%b we=%b reg=%0d data=%h exp 1/1/13/0000d00d", issue_ready, regWrite, writeRegister, writeData);
    end
    n_checks++;
    if (stall_count !== 16'd4) begin n_fail++; $display("FAIL starve_no_stall got %0d exp 4", stall_count); end
  endtask

  task automatic test_reg0();
    idle();
    issue(5'd0, 5'd0, 5'd0, 1'b1);
    wb_valid = 1; wb_rd = 5'd0; wb_data = 32'hFF;
    #1;
    n_checks++;
    if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready got %b exp 1", issue_ready); end
    tick();
    n_checks++;
    if (busy !== 32'h0 || regWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_wb got busy=%h we=%b exp 0/0", busy, regWrite);
    end
    idle();
    lu_valid = 1; lu_rd = 5'd0; lu_data = 32'h77;
    #1;
    n_checks++;
    if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL r0_lu_ready got %b exp 1", lu_ready); end
    tick();
    n_checks++;
    if (regWrite !== 1'b0) begin n_fail++; $display("FAIL r0_lu_we got %b exp 0", regWrite); end
    idle();
    issue_valid = 0; issue_rs = 5'd4; issue_rt = 5'd4; issue_rd = 5'd5; issue_wr = 1;
    tick();
    n_checks++;
    if (busy !== 32'h0 || stall_count !== 16'd4) begin
      n_fail++;
      $display("FAIL invalid_issue got busy=%h stall=%0d exp 0/4", busy, stall_count);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    issue(5'd0, 5'd0, 5'd8, 1'b1);
    tick();
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    tick();
    issue(5'd8, 5'd0, 5'd1, 1'b1);
    tick();
    n_checks++;
    if (busy !== 32'h0000_0300 || stall_count !== 16'd5) begin
      n_fail++;
      $display("FAIL rmid_setup got busy=%h stall=%0d exp 00000300/5", busy, stall_count);
    end
    wb_valid = 1; wb_rd = 5'd20; wb_data = 32'h20;
    lu_valid = 1; lu_rd = 5'd7; lu_data = 32'hDEAD_BEEF;
    tick();
    reset = 1;
    #1;
    n_checks++;
    if (issue_ready !== 1'b0 || lu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_hold got ready=%b lu_ready=%b exp 0/0", issue_ready, lu_ready);
    end
    tick();
    n_checks++;
    if (busy !== 32'h0 || stall_count !== 16'd0 || regWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_cleared got busy=%h stall=%0d we=%b exp 0/0/0", busy, stall_count, regWrite);
    end
    reset = 0;
    wb_valid = 0; lu_valid = 0;
    #1;
    n_checks++;
    if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_resume_ready got %b exp 1", issue_ready); end
    issue_valid = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (regWrite !== 1'b0) begin n_fail++; $display("FAIL rmid_dropped_%0d got we=%b reg=%0d exp we=0", k, regWrite, writeRegister); end
    end
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    test_reset();
    test_issue_stall();
    test_wb_release();
    test_wb_lu_priority();
    test_starve();
    test_reg0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
